exe_scoreboard: RTL and testbench

Issue-side controller for the variable-latency exe stage. It sits between decode and exe and decides each cycle whether the instruction presented by decode may enter exe.
- Tracks in-flight destination registers, for RAW and WAW hazards.
- Reserves the single exe result port per future cycle, for writeback collisions.
- Raises one stall toward decode; exe itself no longer needs to detect collisions.

---
 rtl/tartaruga_pkg.sv | 32 +++
 rtl/exe_scoreboard_if.sv | 24 ++
 rtl/wb_port_reserver.sv | 46 ++++
 rtl/exe_scoreboard.sv | 72 +++++++
 tb/tb_exe_scoreboard.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/tartaruga_pkg.sv
// Shared exe-stage constants and types used by the issue scoreboard and decode/exe glue.
package tartaruga_pkg;

  localparam int unsigned MAX_EXE_STAGES = 4;
  localparam int unsigned WB_DELAY       = 2;
  localparam int unsigned NUM_REGS       = 32;

  localparam int unsigned LAT_W = $clog2(MAX_EXE_STAGES + 1);
  localparam int unsigned CNT_W = $clog2(MAX_EXE_STAGES + WB_DELAY + 1);
  localparam int unsigned OCC_W = MAX_EXE_STAGES - 1;

  typedef logic [LAT_W-1:0] exe_lat_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;
  typedef logic [4:0]       reg_addr_t;

  typedef struct packed {
    logic      valid;
    exe_lat_t  lat;
    logic      we;
    reg_addr_t rd;
    logic      rs1_use;
    reg_addr_t rs1;
    logic      rs2_use;
    reg_addr_t rs2;
  } scoreboard_req_t;

  // A zero latency is illegal; it is issued as a single-cycle op.
  function automatic exe_lat_t sanitize_lat(exe_lat_t lat);
    return (lat == '0) ? exe_lat_t'(1) : lat;
  endfunction

endpackage

// File: rtl/exe_scoreboard_if.sv
// Decode-to-scoreboard issue handshake: request bundle, flush, and the stall/accept answer.
interface exe_scoreboard_if;
  import tartaruga_pkg::*;

  scoreboard_req_t req;
  logic            flush;
  logic            stall;
  logic            accept;

  modport master (
    output req,
    output flush,
    input  stall,
    input  accept
  );

  modport slave (
    input  req,
    input  flush,
    output stall,
    output accept
  );

endinterface

// File: rtl/wb_port_reserver.sv
// Tracks future ownership of the single exe result port; bit k means "owned at cycle now+k".
module wb_port_reserver
  import tartaruga_pkg::*;
(
  input  logic     clk_i,
  input  logic     rstn_i,
  input  exe_lat_t lat_i,
  input  logic     accept_i,
  output logic     collide_o,
  output logic     busy_o
);

  logic [OCC_W-1:0] occ_q, occ_d;

  // The deepest latency maps past the top slot, so it can never collide.
  always_comb begin
    collide_o = 1'b0;
    for (int k = 0; k < int'(OCC_W); k++) begin
      if (int'(lat_i) == k + 1) begin
        collide_o = occ_q[k];
      end
    end
  end

  always_comb begin
    occ_d = occ_q >> 1;
    if (accept_i) begin
      for (int k = 0; k < int'(OCC_W); k++) begin
        if (int'(lat_i) == k + 2) begin
          occ_d[k] = 1'b1;
        end
      end
    end
  end

  assign busy_o = |occ_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/exe_scoreboard.sv
// Issue-side scoreboard: stalls decode on RAW/WAW hazards and exe result-port collisions.
module exe_scoreboard
  import tartaruga_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  exe_scoreboard_if.slave     sb_if,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                busy_o
);

  scoreboard_req_t req;
  exe_lat_t        lat_eff;
  logic            raw, waw, port_collide, port_busy;
  logic            stall, accept;

  sb_cnt_t cnt_q [1:NUM_REGS-1];
  sb_cnt_t cnt_d [1:NUM_REGS-1];

  assign req     = sb_if.req;
  assign lat_eff = sanitize_lat(req.lat);

  // x0 is never tracked, so its pending bit stays low and x0 operands never stall.
  always_comb begin
    pending_o = '0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      pending_o[r] = (cnt_q[r] != '0);
    end
  end

  assign raw = (req.rs1_use & pending_o[req.rs1]) | (req.rs2_use & pending_o[req.rs2]);
  assign waw = req.we & (req.rd != '0) & pending_o[req.rd];

  wb_port_reserver u_port (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .lat_i     (lat_eff),
    .accept_i  (accept),
    .collide_o (port_collide),
    .busy_o    (port_busy)
  );

  assign stall  = req.valid & (raw | waw | port_collide);
  assign accept = req.valid & ~stall & ~sb_if.flush;

  assign sb_if.stall  = stall;
  assign sb_if.accept = accept;
  assign busy_o       = (|pending_o) | port_busy;

  // The new count overrides the decrement; WAW stall guarantees rd was idle.
  always_comb begin
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - sb_cnt_t'(1) : '0;
      if (accept && req.we && (req.rd == reg_addr_t'(r))) begin
        cnt_d[r] = sb_cnt_t'(lat_eff) + sb_cnt_t'(WB_DELAY);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_exe_scoreboard.sv
// Directed bench for exe_scoreboard; driver queues expected per-cycle outputs, monitor checks them.
module tb_exe_scoreboard;
  import tartaruga_pkg::*;

  typedef struct {
    string       name;
    logic        stall;
    logic        accept;
    logic [31:0] pend;
    logic        busy;
  } exp_t;

  logic                clk;
  logic                rstn;
  logic [NUM_REGS-1:0] pending;
  logic                busy;
  int                  n_checks;
  int                  n_fail;
  exp_t                exp_q[$];

  exe_scoreboard_if sb_if ();

  exe_scoreboard u_dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .sb_if     (sb_if),
    .pending_o (pending),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int r);
    return 32'h1 << r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".stall"}, 32'(sb_if.stall), 32'(e.stall));
      chk({e.name, ".accept"}, 32'(sb_if.accept), 32'(e.accept));
      chk({e.name, ".pending"}, pending, e.pend);
      chk({e.name, ".busy"}, 32'(busy), 32'(e.busy));
    end
  end

  always @(negedge clk) begin
    if (rstn && sb_if.req.valid && sb_if.req.lat == '0) begin
      n_fail++;
      $display("FAIL illegal_lat: got lat 0 expected 1..%0d", MAX_EXE_STAGES);
    end
  end

  task automatic drive(input logic v, input int lat, input logic we, input int rd,
                       input logic u1, input int r1, input logic u2, input int r2,
                       input logic fl);
    sb_if.req.valid   = v;
    sb_if.req.lat     = exe_lat_t'(lat);
    sb_if.req.we      = we;
    sb_if.req.rd      = reg_addr_t'(rd);
    sb_if.req.rs1_use = u1;
    sb_if.req.rs1     = reg_addr_t'(r1);
    sb_if.req.rs2_use = u2;
    sb_if.req.rs2     = reg_addr_t'(r2);
    sb_if.flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic push(input string name, input logic st, input logic acc,
                      input logic [31:0] pend, input logic bsy);
    exp_t e;
    e.name   = name;
    e.stall  = st;
    e.accept = acc;
    e.pend   = pend;
    e.busy   = bsy;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string name, input logic st, input logic acc,
                     input logic [31:0] pend, input logic bsy);
    push(name, st, acc, pend, bsy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset state, then L=1 write to x5 pending for three cycles
    idle();                                  cyc("reset_idle", 0, 0, 0, 0);
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);        cyc("l1_issue", 0, 1, 0, 0);
    idle();                                  cyc("l1_p1", 0, 0, b(5), 1);
    idle();                                  cyc("l1_p2", 0, 0, b(5), 1);
    idle();                                  cyc("l1_p3", 0, 0, b(5), 1);
    idle();                                  cyc("l1_clear", 0, 0, 0, 0);

    // 2: RAW on x7 after an L=3 producer
    drive(1, 3, 1, 7, 0, 0, 0, 0, 0);        cyc("raw_prod", 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 1, 7, 0, 0, 0);      cyc($sformatf("raw_stall%0d", i), 1, 0, b(7), 1);
    end
    drive(1, 1, 0, 0, 1, 7, 0, 0, 0);        cyc("raw_go", 0, 1, 0, 0);

    // 3: result-port collisions
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);        cyc("port_a3", 0, 1, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);        cyc("port_l2_hit", 1, 0, 0, 1);
    idle();                                  cyc("port_drain", 0, 0, 0, 1);
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);        cyc("port_b3", 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);        cyc("port_l1_ok", 0, 1, 0, 1);
    idle();                                  cyc("port_drain2", 0, 0, 0, 1);
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);        cyc("port_c3", 0, 1, 0, 0);
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);        cyc("port_l4_ok", 0, 1, 0, 1);
    idle();                                  cyc("port_occ1", 0, 0, 0, 1);
    idle();                                  cyc("port_occ2", 0, 0, 0, 1);
    idle();                                  cyc("port_occ3", 0, 0, 0, 1);
    idle();                                  cyc("port_empty", 0, 0, 0, 0);

    // 4: WAW on x9; x0 write/read and an unused pending rs2 never stall
    drive(1, 2, 1, 9, 0, 0, 0, 0, 0);        cyc("waw_prod", 0, 1, 0, 0);
    drive(1, 4, 1, 9, 0, 0, 0, 0, 0);        cyc("waw_stall", 1, 0, b(9), 1);
    drive(1, 4, 1, 0, 1, 0, 0, 9, 0);        cyc("x0_ok", 0, 1, b(9), 1);
    idle();                                  cyc("x0_p1", 0, 0, b(9), 1);
    idle();                                  cyc("x0_p2", 0, 0, b(9), 1);
    idle();                                  cyc("x0_occ", 0, 0, 0, 1);
    idle();                                  cyc("x0_empty", 0, 0, 0, 0);

    // 5: flush squashes without reserving; older x4 write retires on schedule
    drive(1, 1, 1, 4, 0, 0, 0, 0, 0);        cyc("fl_prod", 0, 1, 0, 0);
    drive(1, 3, 1, 12, 0, 0, 0, 0, 1);       cyc("fl_squash", 0, 0, b(4), 1);
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);        cyc("fl_no_occ", 0, 1, b(4), 1);
    idle();                                  cyc("fl_p3", 0, 0, b(4), 1);
    idle();                                  cyc("fl_clear", 0, 0, 0, 0);

    // 6: asynchronous reset with three writes in flight
    drive(1, 4, 1, 1, 0, 0, 0, 0, 0);        cyc("rst_i1", 0, 1, 0, 0);
    drive(1, 2, 1, 2, 0, 0, 0, 0, 0);        cyc("rst_i2", 0, 1, b(1), 1);
    drive(1, 4, 1, 3, 0, 0, 0, 0, 0);        cyc("rst_i3", 0, 1, b(1) | b(2), 1);
    idle();
    #2 rstn = 1'b0;
    push("rst_async", 0, 0, 0, 0);
    @(negedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 4, 1, 1, 1, 2, 1, 3, 0);        cyc("rst_no_stall", 0, 1, 0, 0);
    idle();                                  cyc("rst_after", 0, 0, b(1), 1);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued expectations expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
